matrix_stream_packer: RTL and testbench

// - Write-side companion to the parallel matrix multiplier.
// - Accepts matrix elements one per handshake in row-major order.
// - Assembles them into the flat packed operand bus the multiplier consumes.
// - Holds the assembled matrix stable until the consumer acknowledges it.
// - One instance per operand (A or B).

---
 rtl/matrix_stream_packer.sv | 134 +++++++++++++
 tb/tb_matrix_stream_packer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_packer.sv
// Collects matrix elements streamed in row-major order into a flat packed operand bus
// and holds the complete matrix until the consumer acknowledges it.
module matrix_stream_packer #(
   parameter int ROWS   = 2,
   parameter int COLS   = 2,
   parameter int ELEM_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      in_valid,
   input  logic [ELEM_W-1:0]         in_data,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic [ROWS*COLS*ELEM_W-1:0] mat_out,
   output logic                      mat_valid,
   input  logic                      consume,
   output logic [$clog2(ROWS):0]     row_idx,
   output logic [$clog2(COLS):0]     col_idx,
   output logic                      err_last
);

   localparam int N   = ROWS * COLS;
   localparam int LEN = N * ELEM_W;
   localparam int RW  = $clog2(ROWS) + 1;
   localparam int CW  = $clog2(COLS) + 1;
   localparam int SW  = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t          state_r;
   state_t          next_s;
   logic            beat_s;
   logic            accept_start_s;
   logic            last_slot_s;
   logic [SW-1:0]   slot_s;
   logic [LEN-1:0]  mat_r;
   logic [RW-1:0]   row_r;
   logic [CW-1:0]   col_r;
   logic            err_r;

   assign beat_s         = in_valid && (state_r == LOAD);
   assign accept_start_s = start && ((state_r == IDLE) || ((state_r == FULL) && consume));
   assign slot_s         = SW'(row_r) * SW'(COLS) + SW'(col_r);
   assign last_slot_s    = (slot_s == SW'(N - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state decode
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = LOAD;
            else       next_s = IDLE;
         end
         LOAD: begin
            if (beat_s && (last_slot_s || in_last)) next_s = FULL;
            else                                    next_s = LOAD;
         end
         FULL: begin
            if (consume) next_s = start ? LOAD : IDLE;
            else         next_s = FULL;
         end
         default: next_s = IDLE;
      endcase
   end

   // Output decode from state only, so in_ready has no path from in_valid
   always_comb begin
      in_ready  = 1'b0;
      mat_valid = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready  = 1'b0;
            mat_valid = 1'b0;
         end
         LOAD: begin
            in_ready  = 1'b1;
            mat_valid = 1'b0;
         end
         FULL: begin
            in_ready  = 1'b0;
            mat_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            mat_valid = 1'b0;
         end
      endcase
   end

   // Element store, slot indices and sticky framing error; a new load clears everything
   always_ff @(posedge clk) begin
      if (rst || accept_start_s) begin
         mat_r <= '0;
         row_r <= '0;
         col_r <= '0;
         err_r <= 1'b0;
      end else if (beat_s) begin
         for (int i = 0; i < N; i++) begin
            if (slot_s == SW'(i)) begin
               mat_r[ELEM_W*(N-1-i) +: ELEM_W] <= in_data;
            end
         end
         if (col_r == CW'(COLS - 1)) begin
            col_r <= '0;
            row_r <= row_r + RW'(1);
         end else begin
            col_r <= col_r + CW'(1);
         end
         if (last_slot_s != in_last) begin
            err_r <= 1'b1;
         end
      end
   end

   assign mat_out  = mat_r;
   assign row_idx  = row_r;
   assign col_idx  = col_r;
   assign err_last = err_r;

endmodule

// File: tb/tb_matrix_stream_packer.sv
// Directed bench for matrix_stream_packer in its 2x2, 8-bit configuration.
module tb_matrix_stream_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_ready;
   logic [31:0] mat_out;
   logic        mat_valid;
   logic        consume;
   logic [1:0]  row_idx;
   logic [1:0]  col_idx;
   logic        err_last;

   int pass_cnt  = 0;
   int total_cnt = 0;

   matrix_stream_packer #(.ROWS(2), .COLS(2), .ELEM_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .mat_out(mat_out), .mat_valid(mat_valid),
      .consume(consume), .row_idx(row_idx), .col_idx(col_idx), .err_last(err_last)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle so outputs are sampled away from the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      in_valid = 1'b1; in_data = d; in_last = l;
      cyc();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; consume = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      total_cnt++;
      if ({mat_out, mat_valid, in_ready, row_idx, col_idx, err_last} !== 39'd0)
         $display("FAIL reset_outputs got mat=%h v=%b r=%b row=%0d col=%0d err=%b want all 0",
                  mat_out, mat_valid, in_ready, row_idx, col_idx, err_last);
      else pass_cnt++;
   endtask

   task automatic test_basic_load();
      start = 1'b1; cyc(); start = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL basic_ready got %b want 1", in_ready);
      else pass_cnt++;
      beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0);
      total_cnt++;
      if (mat_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", mat_valid);
      else pass_cnt++;
      beat(8'h04, 1'b1);
      total_cnt++;
      if (mat_out !== 32'h01020304) $display("FAIL basic_mat got %h want 01020304", mat_out);
      else pass_cnt++;
      total_cnt++;
      if ({mat_valid, in_ready, err_last} !== 3'b100)
         $display("FAIL basic_flags got v/r/e=%b%b%b want 100", mat_valid, in_ready, err_last);
      else pass_cnt++;
      consume = 1'b1; cyc(); consume = 1'b0;
      total_cnt++;
      if (mat_valid !== 1'b0) $display("FAIL basic_consume got %b want 0", mat_valid);
      else pass_cnt++;
   endtask

   task automatic test_stalls();
      logic [3:0] exp_idx [4];
      exp_idx[0] = 4'b0000; exp_idx[1] = 4'b0001; exp_idx[2] = 4'b0100; exp_idx[3] = 4'b0101;
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < i; g++) cyc();
         total_cnt++;
         if ({row_idx, col_idx} !== exp_idx[i])
            $display("FAIL stall_idx%0d got row=%0d col=%0d want %0d/%0d",
                     i, row_idx, col_idx, exp_idx[i][3:2], exp_idx[i][1:0]);
         else pass_cnt++;
         beat(8'(i + 1), i == 3);
      end
      total_cnt++;
      if (mat_out !== 32'h01020304 || mat_valid !== 1'b1)
         $display("FAIL stall_mat got %h v=%b want 01020304 v=1", mat_out, mat_valid);
      else pass_cnt++;
      consume = 1'b1; cyc(); consume = 1'b0;
   endtask

   task automatic test_early_last();
      start = 1'b1; cyc(); start = 1'b0;
      beat(8'h7F, 1'b0); beat(8'h80, 1'b1);
      total_cnt++;
      if (mat_out !== 32'h7F800000 || mat_valid !== 1'b1 || err_last !== 1'b1)
         $display("FAIL early_last got %h v=%b e=%b want 7f800000 v=1 e=1", mat_out, mat_valid, err_last);
      else pass_cnt++;
      consume = 1'b1; start = 1'b1; cyc(); consume = 1'b0; start = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b1 || mat_valid !== 1'b0 || err_last !== 1'b0 || mat_out !== 32'h0)
         $display("FAIL restart got r=%b v=%b e=%b mat=%h want r=1 v=0 e=0 mat=0",
                  in_ready, mat_valid, err_last, mat_out);
      else pass_cnt++;
   endtask

   task automatic test_missing_last();
      beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
      total_cnt++;
      if (mat_out !== 32'h11223344 || mat_valid !== 1'b1 || err_last !== 1'b1)
         $display("FAIL missing_last got %h v=%b e=%b want 11223344 v=1 e=1", mat_out, mat_valid, err_last);
      else pass_cnt++;
   endtask

   task automatic test_back_pressure();
      in_valid = 1'b1; in_data = 8'hFF; consume = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         total_cnt++;
         if (in_ready !== 1'b0 || mat_valid !== 1'b1 || mat_out !== 32'h11223344)
            $display("FAIL backpressure%0d got r=%b v=%b mat=%h want r=0 v=1 mat=11223344",
                     i, in_ready, mat_valid, mat_out);
         else pass_cnt++;
      end
      in_valid = 1'b0; consume = 1'b1; cyc(); consume = 1'b0;
      total_cnt++;
      if (mat_valid !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL bp_release got v=%b r=%b want v=0 r=0", mat_valid, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      start = 1'b1; cyc(); start = 1'b0;
      beat(8'hAA, 1'b0);
      start = 1'b1; beat(8'hBB, 1'b0); start = 1'b0;
      total_cnt++;
      if (row_idx !== 2'd1 || col_idx !== 2'd0 || mat_out !== 32'hAABB0000)
         $display("FAIL load_ignores_start got row=%0d col=%0d mat=%h want 1/0 aabb0000",
                  row_idx, col_idx, mat_out);
      else pass_cnt++;
      rst = 1'b1; cyc(); rst = 1'b0;
      total_cnt++;
      if ({mat_out, mat_valid, in_ready, row_idx, col_idx, err_last} !== 39'd0)
         $display("FAIL mid_reset got mat=%h v=%b r=%b row=%0d col=%0d err=%b want all 0",
                  mat_out, mat_valid, in_ready, row_idx, col_idx, err_last);
      else pass_cnt++;
      in_valid = 1'b1; in_data = 8'hCC; cyc(); cyc(); in_valid = 1'b0;
      total_cnt++;
      if (in_ready !== 1'b0 || mat_out !== 32'h0 || col_idx !== 2'd0)
         $display("FAIL need_start got r=%b mat=%h col=%0d want r=0 mat=0 col=0", in_ready, mat_out, col_idx);
      else pass_cnt++;
      start = 1'b1; cyc(); start = 1'b0;
      beat(8'hCC, 1'b0);
      total_cnt++;
      if (mat_out !== 32'hCC000000 || col_idx !== 2'd1)
         $display("FAIL after_restart got mat=%h col=%0d want cc000000 col=1", mat_out, col_idx);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_stalls();
      test_early_last();
      test_missing_last();
      test_back_pressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
